// File: rtl/tri_state_io.sv
// tri_state_io
//   Vectorized bidirectional pad buffer for single-wire sensor buses such as
//   DHT11 data lines. Each bit drives its pad from send when dir is 1,
//   otherwise it releases the pad to high-Z. The pad level is always sampled,
//   including while this block drives it. It then passes through a
//   synchronizer chain and a per-bit glitch filter. The filter output is
//   read. One-cycle rise/fall pulses mark each accepted change of read.
//
//   Build option:
//     TRI_STATE_OPEN_DRAIN_EN  defined   -> open-drain drive. A pad is pulled
//                                           low only for dir=1, send=0. A
//                                           high level comes from the
//                                           external pull-up.
//                              undefined -> push-pull drive (default).
//
//   Parameters:
//     WIDTH        number of independent pad bits
//     SYNC_STAGES  synchronizer depth per bit (1..4)
//     FILTER_LEN   consecutive samples needed to accept a new level (1..15)
//
//   Ports:
//     clk   in     system clock
//     rst   in     synchronous active-high reset; releases all pads
//     pad   inout  physical data lines (externally pulled up)
//     dir   in     per-bit direction, 1 = drive pad
//     send  in     per-bit drive value
//     read  out    synchronized, filtered pad level
//     rise  out    one-cycle pulse on read 0->1
//     fall  out    one-cycle pulse on read 1->0

module tri_state_io #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] pad,
    input  logic [WIDTH-1:0] dir,
    input  logic [WIDTH-1:0] send,
    output logic [WIDTH-1:0] read,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("tri_state_io: SYNC_STAGES must be in 1..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
        $error("tri_state_io: FILTER_LEN must be in 1..15");
    end

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    // Drive path: purely combinational, so a pad follows dir/send in the
    // same cycle. Reset overrides dir and releases every pad.
    for (genvar i = 0; i < WIDTH; i++) begin : g_drive
`ifdef TRI_STATE_OPEN_DRAIN_EN
        assign pad[i] = (dir[i] && !rst && !send[i]) ? 1'b0 : 1'bz;
`else
        assign pad[i] = (dir[i] && !rst) ? send[i] : 1'bz;
`endif
    end

    // Synchronizer chain. Stages reset to 1 to match an idle-high bus, so
    // leaving reset never produces a spurious edge.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= pad;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Glitch filter. cnt counts consecutive samples that disagree with
    // read. Any sample that agrees with read restarts the count. The pulses
    // are registered alongside read, so they line up with the level change.
    logic [3:0] cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            read <= '1;
            rise <= '0;
            fall <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                if (sync_out[b] == read[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    read[b] <= sync_out[b];
                    rise[b] <= sync_out[b];
                    fall[b] <= ~sync_out[b];
                    cnt[b]  <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tri_state_io.sv
module tb_tri_state_io;

    localparam int W = 32;
    localparam int S = 2;
    localparam int F = 3;

    logic         clk = 1'b0;
    logic         rst;
    wire  [W-1:0] pad;
    logic [W-1:0] dir, send, read, rise, fall;
    logic [W-1:0] tb_oe, tb_val;

    always #5 clk = ~clk;

    for (genvar g = 0; g < W; g++) begin : g_pad
        assign pad[g] = tb_oe[g] ? tb_val[g] : 1'bz;
        pullup (pad[g]);
    end

    tri_state_io #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
        .clk(clk), .rst(rst), .pad(pad), .dir(dir), .send(send),
        .read(read), .rise(rise), .fall(fall)
    );

    int checks = 0;
    int failures = 0;

    // Reference model. Each edge sees the pad level sampled S edges
    // earlier. read changes once F consecutive seen samples disagree with it.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_read, m_rise, m_fall;
    int           run [W];
    int           rise_cnt [W];
    int           fall_cnt [W];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected resolved pad level. The pull-up supplies 1 for undriven
    // bits. Both drive modes give the same level.
    function automatic logic [W-1:0] pad_model();
        logic [W-1:0] p;
        for (int b = 0; b < W; b++) begin
            if (dir[b] && !rst) p[b] = send[b];
            else if (tb_oe[b])  p[b] = tb_val[b];
            else                p[b] = 1'b1;
        end
        return p;
    endfunction

    task automatic clear_cnt();
        for (int b = 0; b < W; b++) begin
            rise_cnt[b] = 0;
            fall_cnt[b] = 0;
        end
    endtask

    task automatic step();
        logic [W-1:0] pexp, seen;
        logic         rst_s;
        #1;
        pexp  = pad_model();
        rst_s = rst;
        chk("pad", pad, pexp);
        @(posedge clk);
        #1;
        if (rst_s) begin
            hist.delete();
            for (int k = 0; k < S; k++) hist.push_back('1);
            m_read = '1;
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) run[b] = 0;
        end else begin
            seen = hist.pop_front();
            hist.push_back(pexp);
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                if (seen[b] !== m_read[b]) begin
                    run[b]++;
                    if (run[b] == F) begin
                        m_read[b] = seen[b];
                        m_rise[b] = seen[b];
                        m_fall[b] = ~seen[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
        chk("read", read, m_read);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("rise_and_fall", rise & fall, '0);
        for (int b = 0; b < W; b++) begin
            if (rise[b] === 1'b1) rise_cnt[b]++;
            if (fall[b] === 1'b1) fall_cnt[b]++;
        end
    endtask

    // Counts edges until read[idx] reaches val; returns -1 when the bound expires.
    task automatic wait_read(input int idx, input logic val, input int max_edges, output int n);
        n = -1;
        for (int e = 1; e <= max_edges; e++) begin
            step();
            if (read[idx] === val) begin
                n = e;
                break;
            end
        end
    endtask

    int n;
    int low_cycles;

    initial begin
        rst = 1'b1; dir = '0; send = '0; tb_oe = '0; tb_val = '1;
        for (int b = 0; b < W; b++) run[b] = 0;
        m_read = '1; m_rise = '0; m_fall = '0;
        repeat (S) hist.push_back('1);
        clear_cnt();

        // Reset: pads released, read idle high.
        repeat (3) step();
        chk("reset_read", read, '1);
        chk("reset_pulses", rise | fall, '0);
        dir = '1; send = '0;
        step();
        chk("reset_pad_released", pad, '1);

        // Drive bit 5 low: immediate pad change, read follows after S+F edges.
        rst = 1'b0; dir = '0; dir[5] = 1'b1; send = '0;
        #1;
        chk("drive_pad5_same_cycle", {31'd0, pad[5]}, '0);
        chk("drive_other_pads", pad | (W'(1) << 5), '1);
        clear_cnt();
        wait_read(5, 1'b0, 12, n);
        chk_int("drive_latency", n, S + F);
        repeat (4) step();
        chk_int("drive_fall_pulses", fall_cnt[5], 1);
        chk("drive_others_high", read | (W'(1) << 5), '1);

        // Input release on bit 0.
        dir = '0;
        repeat (8) step();
        clear_cnt();
        tb_oe[0] = 1'b1; tb_val[0] = 1'b0;
        wait_read(0, 1'b0, 12, n);
        chk_int("release_fall_latency", n, S + F);
        repeat (80 - n) step();
        tb_oe[0] = 1'b0;
        wait_read(0, 1'b1, 12, n);
        chk_int("release_rise_latency", n, S + F);
        repeat (4) step();
        chk_int("release_fall_pulses", fall_cnt[0], 1);
        chk_int("release_rise_pulses", rise_cnt[0], 1);

        // Glitch on bit 3: 2 cycles rejected, 3 cycles accepted.
        clear_cnt();
        low_cycles = 0;
        tb_oe[3] = 1'b1; tb_val[3] = 1'b0;
        repeat (2) begin step(); if (read[3] === 1'b0) low_cycles++; end
        tb_oe[3] = 1'b0;
        repeat (10) begin step(); if (read[3] === 1'b0) low_cycles++; end
        chk_int("glitch2_low_cycles", low_cycles, 0);
        chk_int("glitch2_pulses", rise_cnt[3] + fall_cnt[3], 0);
        low_cycles = 0;
        tb_oe[3] = 1'b1;
        repeat (3) begin step(); if (read[3] === 1'b0) low_cycles++; end
        tb_oe[3] = 1'b0;
        repeat (12) begin step(); if (read[3] === 1'b0) low_cycles++; end
        chk_int("glitch3_low_cycles", low_cycles, 3);
        chk_int("glitch3_fall_pulses", fall_cnt[3], 1);
        chk_int("glitch3_rise_pulses", rise_cnt[3], 1);

        // Mid-operation reset discards a pending count on bit 7.
        clear_cnt();
        tb_oe[7] = 1'b1; tb_val[7] = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("midreset_read", read, '1);
        chk("midreset_pulses", rise | fall, '0);
        rst = 1'b0; tb_oe[7] = 1'b0;
        repeat (10) step();
        chk_int("midreset_no_fall", fall_cnt[7], 0);
        chk_int("midreset_no_rise", rise_cnt[7], 0);

        // Randomized traffic with slowly changing levels so that both
        // accepted edges and rejected glitches occur.
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(11) == 0) dir[b]    = ~dir[b];
                if ($urandom_range(5)  == 0) send[b]   = ~send[b];
                if ($urandom_range(5)  == 0) tb_val[b] = ~tb_val[b];
                if ($urandom_range(7)  == 0) tb_oe[b]  = ~tb_oe[b];
            end
            tb_oe = tb_oe & ~dir;
            rst = ($urandom_range(199) == 0);
            step();
        end

        rst = 1'b0; dir = '0; tb_oe = '0;
        repeat (S + F + 2) step();
        chk("final_idle_read", read, '1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
